// File: rtl/blockram_port_arbiter.sv
// blockram_port_arbiter: round-robin read/write arbiter with response FIFO and zero-fill flush in front of one dual-port RAM
module blockram_port_arbiter #(
  parameter int NUM_REQUEST                = 4,
  parameter int SINGLE_ENTRY_WIDTH_IN_BITS = 64,
  parameter int NUM_SET                    = 64,
  parameter int SET_PTR_WIDTH_IN_BITS      = $clog2(NUM_SET),
  parameter int WRITE_MASK_LEN             = SINGLE_ENTRY_WIDTH_IN_BITS / 8,
  parameter int REQUEST_ID_WIDTH           = $clog2(NUM_REQUEST)
) (
  input  logic                                              clk_in,
  input  logic                                              reset_n_in,
  input  logic [NUM_REQUEST-1:0]                            request_valid_in,
  input  logic [NUM_REQUEST-1:0]                            request_is_write_in,
  input  logic [NUM_REQUEST*SET_PTR_WIDTH_IN_BITS-1:0]      request_addr_in,
  input  logic [NUM_REQUEST*SINGLE_ENTRY_WIDTH_IN_BITS-1:0] request_data_in,
  input  logic [NUM_REQUEST*WRITE_MASK_LEN-1:0]             request_write_mask_in,
  output logic [NUM_REQUEST-1:0]                            request_ready_out,
  output logic                                              response_valid_out,
  input  logic                                              response_ready_in,
  output logic [REQUEST_ID_WIDTH-1:0]                       response_id_out,
  output logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0]             response_data_out,
  output logic                                              response_hit_out,
  input  logic                                              flush_in,
  output logic                                              busy_out,
  output logic                                              flush_done_out,
  output logic                                              ram_write_access_en_out,
  output logic [WRITE_MASK_LEN-1:0]                         ram_write_en_out,
  output logic [SET_PTR_WIDTH_IN_BITS-1:0]                  ram_write_set_addr_out,
  output logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0]             ram_write_data_out,
  output logic                                              ram_read_access_en_out,
  output logic [SET_PTR_WIDTH_IN_BITS-1:0]                  ram_read_set_addr_out,
  input  logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0]             ram_read_data_in,
  input  logic                                              ram_read_valid_in
);
  localparam int N  = NUM_REQUEST;
  localparam int SW = SET_PTR_WIDTH_IN_BITS;
  localparam int DW = SINGLE_ENTRY_WIDTH_IN_BITS;
  localparam int MW = WRITE_MASK_LEN;
  localparam int IW = REQUEST_ID_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_DONE} state_t;

  state_t              r_state, w_state_nxt;
  logic [SW-1:0]       r_flush_cnt;
  logic [IW-1:0]       r_wr_ptr, r_rd_ptr, r_inflight_id;
  logic                r_inflight;
  logic [1:0][DW-1:0]  r_fifo_data;
  logic [1:0][IW-1:0]  r_fifo_id;
  logic [1:0]          r_fifo_hit;
  logic                r_head, r_tail;
  logic [1:0]          r_occ;

  logic [IW:0]   w_wr_pick, w_rd_pick;
  logic [IW-1:0] w_wr_id, w_rd_id;
  logic [SW-1:0] w_wr_addr, w_rd_addr;
  logic [DW-1:0] w_wr_data;
  logic [MW-1:0] w_wr_mask;
  logic          w_arb_en, w_wr_gnt, w_rd_gnt, w_pop, w_credit, w_hazard, w_flushing;

  // Priority starts one past the last granted index; lowest offset wins.
  function automatic logic [IW:0] rr_pick(input logic [N-1:0] req, input logic [IW-1:0] ptr);
    logic [IW:0] res;
    res = '0;
    for (int k = N; k >= 1; k--)
      if (req[(int'(ptr) + k) % N]) res = {1'b1, IW'((int'(ptr) + k) % N)};
    return res;
  endfunction

  assign w_wr_pick  = rr_pick(request_valid_in & request_is_write_in, r_wr_ptr);
  assign w_rd_pick  = rr_pick(request_valid_in & ~request_is_write_in, r_rd_ptr);
  assign w_wr_id    = w_wr_pick[IW-1:0];
  assign w_rd_id    = w_rd_pick[IW-1:0];
  assign w_wr_addr  = request_addr_in[w_wr_id*SW +: SW];
  assign w_rd_addr  = request_addr_in[w_rd_id*SW +: SW];
  assign w_wr_data  = request_data_in[w_wr_id*DW +: DW];
  assign w_wr_mask  = request_write_mask_in[w_wr_id*MW +: MW];

  assign w_flushing = r_state == S_FLUSH;
  assign w_arb_en   = reset_n_in & (r_state == S_IDLE) & ~flush_in;
  assign w_pop      = response_valid_out & response_ready_in;
  // Outstanding reads (buffered + in flight) must leave room in the 2-entry FIFO.
  assign w_credit   = ({1'b0, r_occ} + {2'b00, r_inflight}) < ({2'b00, w_pop} + 3'd2);
  assign w_wr_gnt   = w_arb_en & w_wr_pick[IW];
  assign w_hazard   = w_wr_gnt & (w_rd_addr == w_wr_addr) & (|w_wr_mask);
  assign w_rd_gnt   = w_arb_en & w_rd_pick[IW] & w_credit & ~w_hazard;

  assign request_ready_out = ({{(N-1){1'b0}}, w_wr_gnt} << w_wr_id) | ({{(N-1){1'b0}}, w_rd_gnt} << w_rd_id);

  assign ram_write_access_en_out = w_flushing | w_wr_gnt;
  assign ram_write_en_out        = w_flushing ? '1 : (w_wr_gnt ? w_wr_mask : '0);
  assign ram_write_set_addr_out  = w_flushing ? r_flush_cnt : w_wr_addr;
  assign ram_write_data_out      = w_flushing ? '0 : w_wr_data;
  assign ram_read_access_en_out  = w_rd_gnt;
  assign ram_read_set_addr_out   = w_rd_addr;

  assign response_valid_out = r_occ != 2'd0;
  assign response_id_out    = r_fifo_id[r_head];
  assign response_data_out  = r_fifo_data[r_head];
  assign response_hit_out   = r_fifo_hit[r_head];
  assign busy_out           = r_state != S_IDLE;
  assign flush_done_out     = r_state == S_DONE;

  always_comb begin
    w_state_nxt = (r_state == S_IDLE && flush_in)                  ? S_FLUSH :
                  (w_flushing && r_flush_cnt == SW'(NUM_SET - 1)) ? S_DONE  :
                  (r_state == S_DONE)                              ? S_IDLE  : r_state;
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_state       <= S_IDLE;
      r_flush_cnt   <= '0;
      r_wr_ptr      <= IW'(N - 1);
      r_rd_ptr      <= IW'(N - 1);
      r_inflight    <= 1'b0;
      r_inflight_id <= '0;
      r_fifo_data   <= '0;
      r_fifo_id     <= '0;
      r_fifo_hit    <= '0;
      r_head        <= 1'b0;
      r_tail        <= 1'b0;
      r_occ         <= 2'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_flush_cnt <= w_flushing ? r_flush_cnt + 1'b1 : '0;
      if (w_wr_gnt) r_wr_ptr <= w_wr_id;
      if (w_rd_gnt) begin
        r_rd_ptr      <= w_rd_id;
        r_inflight_id <= w_rd_id;
      end
      r_inflight <= w_rd_gnt;
      if (r_inflight) begin
        r_fifo_data[r_tail] <= ram_read_data_in;
        r_fifo_hit[r_tail]  <= ram_read_valid_in;
        r_fifo_id[r_tail]   <= r_inflight_id;
      end
      r_tail <= r_tail ^ r_inflight;
      r_head <= r_head ^ w_pop;
      r_occ  <= r_occ + {1'b0, r_inflight} - {1'b0, w_pop};
    end
  end
endmodule

// File: tb/tb_blockram_port_arbiter.sv
// tb_blockram_port_arbiter: vector table, directed corner sequences and random traffic against a queue-based reference model
module tb_blockram_port_arbiter;
  localparam int N = 4, DW = 64, NS = 64, SW = 6, MW = 8, IW = 2;

  logic clk_in = 1'b0, reset_n_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic [N-1:0]    req_v = '0, req_w = '0;
  logic [N*SW-1:0] req_a = '0;
  logic [N*DW-1:0] req_d = '0;
  logic [N*MW-1:0] req_m = '0;
  logic            resp_rdy = 1'b1, flush = 1'b0;

  logic [N-1:0]  request_ready_out;
  logic          response_valid_out, response_hit_out, busy_out, flush_done_out;
  logic [IW-1:0] response_id_out;
  logic [DW-1:0] response_data_out, ram_write_data_out;
  logic          ram_write_access_en_out, ram_read_access_en_out;
  logic [MW-1:0] ram_write_en_out;
  logic [SW-1:0] ram_write_set_addr_out, ram_read_set_addr_out;
  logic [DW-1:0] ram_rdata = '0;
  logic          ram_rvalid = 1'b0;

  blockram_port_arbiter dut (
    .clk_in(clk_in), .reset_n_in(reset_n_in),
    .request_valid_in(req_v), .request_is_write_in(req_w), .request_addr_in(req_a),
    .request_data_in(req_d), .request_write_mask_in(req_m), .request_ready_out(request_ready_out),
    .response_valid_out(response_valid_out), .response_ready_in(resp_rdy),
    .response_id_out(response_id_out), .response_data_out(response_data_out),
    .response_hit_out(response_hit_out), .flush_in(flush), .busy_out(busy_out),
    .flush_done_out(flush_done_out), .ram_write_access_en_out(ram_write_access_en_out),
    .ram_write_en_out(ram_write_en_out), .ram_write_set_addr_out(ram_write_set_addr_out),
    .ram_write_data_out(ram_write_data_out), .ram_read_access_en_out(ram_read_access_en_out),
    .ram_read_set_addr_out(ram_read_set_addr_out), .ram_read_data_in(ram_rdata),
    .ram_read_valid_in(ram_rvalid)
  );

  // Read-first RAM with per-set valid bits
  bit [DW-1:0] ram_mem [NS];
  bit          ram_vld [NS];
  always @(posedge clk_in) begin
    if (ram_read_access_en_out) begin
      ram_rdata  <= ram_mem[ram_read_set_addr_out];
      ram_rvalid <= ram_vld[ram_read_set_addr_out];
    end
    if (ram_write_access_en_out) begin
      for (int b = 0; b < MW; b++)
        if (ram_write_en_out[b]) ram_mem[ram_write_set_addr_out][b*8 +: 8] <= ram_write_data_out[b*8 +: 8];
      ram_vld[ram_write_set_addr_out] <= 1'b1;
    end
  end

  int total = 0, bad = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: integer pointers, a queue of expected responses, shadow memory
  typedef struct { logic [DW-1:0] d; bit h; int id; int avail; } resp_t;
  resp_t       mq[$];
  bit [DW-1:0] m_mem [NS];
  bit          m_vld [NS];
  int m_wl = N - 1, m_rl = N - 1, m_phase = 0, m_fidx = 0, cyc = 0;

  function automatic int rr(input logic [N-1:0] req, input int last);
    for (int k = 1; k <= N; k++) if (req[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  always @(negedge clk_in) begin : mon
    logic [N-1:0] er;
    int ww, rw, a;
    bit rv, pop, haz;
    cyc++;
    if (!reset_n_in) begin
      chk("rst_ready", request_ready_out, 0);
      chk("rst_rvalid", response_valid_out, 0);
      chk("rst_busy", busy_out, 0);
      mq.delete(); m_wl = N - 1; m_rl = N - 1; m_phase = 0;
    end else begin
      rv  = mq.size() > 0 && mq[0].avail <= cyc;
      pop = rv && resp_rdy;
      chk("m_rvalid", response_valid_out, rv);
      if (rv && response_valid_out) begin
        chk("m_rid", response_id_out, mq[0].id);
        chk("m_rdata", response_data_out, mq[0].d);
        chk("m_rhit", response_hit_out, mq[0].h);
      end
      chk("m_busy", busy_out, m_phase != 0);
      chk("m_done", flush_done_out, m_phase == 2);
      er = '0; ww = -1; rw = -1;
      if (m_phase == 0 && !flush) begin
        ww  = rr(req_v & req_w, m_wl);
        rw  = rr(req_v & ~req_w, m_rl);
        haz = ww >= 0 && rw >= 0 && req_a[rw*SW +: SW] == req_a[ww*SW +: SW] && req_m[ww*MW +: MW] != 0;
        if (ww >= 0) er[ww] = 1'b1;
        if (rw >= 0 && (mq.size() - int'(pop)) < 2 && !haz) er[rw] = 1'b1;
        else rw = -1;
      end
      chk("m_ready", request_ready_out, er);
      if (pop) void'(mq.pop_front());
      if (rw >= 0) begin
        a = int'(req_a[rw*SW +: SW]);
        mq.push_back(resp_t'{m_mem[a], m_vld[a], rw, cyc + 2});
        m_rl = rw;
      end
      if (ww >= 0) begin
        a = int'(req_a[ww*SW +: SW]);
        chk("m_wr_addr", ram_write_set_addr_out, a);
        chk("m_wr_en", ram_write_en_out, req_m[ww*MW +: MW]);
        for (int b = 0; b < MW; b++)
          if (req_m[ww*MW + b]) m_mem[a][b*8 +: 8] = req_d[ww*DW + b*8 +: 8];
        m_vld[a] = 1'b1;
        m_wl = ww;
      end
      if (m_phase == 1) begin
        chk("m_fl_acc", ram_write_access_en_out, 1);
        chk("m_fl_addr", ram_write_set_addr_out, m_fidx);
        chk("m_fl_en", ram_write_en_out, 8'hFF);
        chk("m_fl_data", ram_write_data_out, 0);
        m_mem[m_fidx] = '0; m_vld[m_fidx] = 1'b1;
        if (m_fidx == NS - 1) m_phase = 2; else m_fidx++;
      end else if (m_phase == 2) m_phase = 0;
      else if (flush) begin m_phase = 1; m_fidx = 0; end
    end
  end

  task automatic step();
    @(posedge clk_in); #1;
  endtask
  task automatic idle(input int n);
    req_v = '0;
    repeat (n) step();
  endtask
  task automatic set_req(input int i, input bit v, input bit w, input logic [SW-1:0] a,
                         input logic [DW-1:0] d, input logic [MW-1:0] m);
    req_v[i] = v; req_w[i] = w; req_a[i*SW +: SW] = a; req_d[i*DW +: DW] = d; req_m[i*MW +: MW] = m;
  endtask

  typedef struct { logic [N-1:0] v, w, exp; } vec_t;
  vec_t tbl [8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [N-1:0] g;
    int gq[$], rq[$];
    tbl = '{'{4'b1111, 4'b0000, 4'b0001}, '{4'b1111, 4'b0000, 4'b0010},
            '{4'b1111, 4'b1111, 4'b0001}, '{4'b1111, 4'b1010, 4'b0110},
            '{4'b0101, 4'b0001, 4'b0101}, '{4'b0000, 4'b0000, 4'b0000},
            '{4'b1001, 4'b0000, 4'b1000}, '{4'b1111, 4'b0110, 4'b0011}};
    repeat (3) @(posedge clk_in);
    #1 reset_n_in = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 0, 0, SW'(i * 3 + 1), {16{4'(i + 1)}}, 8'hFF);
    for (int i = 0; i < 8; i++) begin
      req_v = tbl[i].v; req_w = tbl[i].w;
      @(negedge clk_in); chk("vec_ready", request_ready_out, tbl[i].exp);
      step();
    end
    idle(4);

    set_req(0, 1, 1, 5, 64'h1122334455667788, 8'hFF);
    @(negedge clk_in); chk("wr5_ready", request_ready_out, 4'b0001);
    step(); set_req(0, 1, 0, 5, 0, 0);
    @(negedge clk_in); chk("rd5_ready", request_ready_out, 4'b0001);
    step(); req_v = '0;
    @(negedge clk_in); chk("rd5_early", response_valid_out, 0);
    step();
    @(negedge clk_in);
    chk("rd5_valid", response_valid_out, 1); chk("rd5_id", response_id_out, 0);
    chk("rd5_data", response_data_out, 64'h1122334455667788); chk("rd5_hit", response_hit_out, 1);
    idle(3);

    set_req(0, 1, 1, 9, {8{8'hAA}}, 8'hFF); set_req(1, 1, 0, 9, 0, 0);
    @(negedge clk_in); chk("haz_ready0", request_ready_out, 4'b0001);
    step(); req_v[0] = 1'b0;
    @(negedge clk_in); chk("haz_ready1", request_ready_out, 4'b0010);
    step(); req_v = '0; step();
    @(negedge clk_in);
    chk("haz_valid", response_valid_out, 1); chk("haz_id", response_id_out, 1);
    chk("haz_data", response_data_out, {8{8'hAA}});
    idle(3);

    resp_rdy = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, 1, 0, SW'(i), 0, 0);
    repeat (6) begin
      @(negedge clk_in); g = req_v & request_ready_out;
      for (int i = 0; i < N; i++) if (g[i]) gq.push_back(i);
      step(); req_v &= ~g;
    end
    @(negedge clk_in);
    chk("bp_grants", gq.size(), 2); chk("bp_rvalid", response_valid_out, 1);
    step(); resp_rdy = 1'b1;
    for (int c = 0; c < 30 && rq.size() < 4; c++) begin
      @(negedge clk_in); g = req_v & request_ready_out;
      for (int i = 0; i < N; i++) if (g[i]) gq.push_back(i);
      if (response_valid_out) rq.push_back(int'(response_id_out));
      step(); req_v &= ~g;
    end
    chk("bp_total_grants", gq.size(), 4); chk("bp_total_resps", rq.size(), 4);
    for (int i = 0; i < 4 && i < gq.size() && i < rq.size(); i++) chk("bp_order", rq[i], gq[i]);
    idle(3);

    set_req(0, 1, 0, 5, 0, 0); flush = 1'b1;
    @(negedge clk_in); chk("fl_ready_t", request_ready_out, 0);
    step(); flush = 1'b0;
    for (int k = 0; k < NS; k++) begin
      @(negedge clk_in);
      chk("fl_ready", request_ready_out, 0); chk("fl_addr", ram_write_set_addr_out, k);
      chk("fl_en", ram_write_en_out, 8'hFF); chk("fl_data", ram_write_data_out, 0);
      step();
    end
    @(negedge clk_in); chk("fl_done", flush_done_out, 1); chk("fl_ready_done", request_ready_out, 0);
    step();
    @(negedge clk_in); chk("fl_regrant", request_ready_out, 4'b0001);
    step(); req_v = '0; step();
    @(negedge clk_in);
    chk("fl_rd_valid", response_valid_out, 1); chk("fl_rd_data", response_data_out, 0);
    chk("fl_rd_hit", response_hit_out, 1);
    idle(3);

    resp_rdy = 1'b0; set_req(0, 1, 0, 7, 0, 0);
    @(negedge clk_in); chk("rs_grant", request_ready_out, 4'b0001);
    step(); req_v = '0; flush = 1'b1;
    step(); flush = 1'b0;
    repeat (10) step();
    chk("rs_cnt10", ram_write_set_addr_out, 10); chk("rs_buffered", response_valid_out, 1);
    reset_n_in = 1'b0; #1;
    chk("rs_ready", request_ready_out, 0); chk("rs_rvalid", response_valid_out, 0);
    chk("rs_busy", busy_out, 0); chk("rs_wacc", ram_write_access_en_out, 0);
    chk("rs_racc", ram_read_access_en_out, 0); chk("rs_done", flush_done_out, 0);
    chk("rs_rdata", response_data_out, 0);
    step(); step(); reset_n_in = 1'b1; resp_rdy = 1'b1;
    @(negedge clk_in); chk("rs_busy_after", busy_out, 0); chk("rs_rvalid_after", response_valid_out, 0);
    step();
    for (int i = 0; i < N; i++) set_req(i, 1, 0, SW'(i), 0, 0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk_in); chk("rr_order", request_ready_out, 4'b0001 << (k % 4));
      step();
    end
    idle(4);

    for (int c = 0; c < 2000; c++) begin
      @(negedge clk_in); g = req_v & request_ready_out;
      step();
      for (int i = 0; i < N; i++)
        if (!req_v[i] || g[i]) begin
          if ($urandom_range(0, 9) < 7)
            set_req(i, 1, 1'($urandom_range(0, 1)), SW'($urandom_range(0, 7)),
                    {$urandom, $urandom}, 8'($urandom_range(1, 255)));
          else req_v[i] = 1'b0;
        end
      resp_rdy = $urandom_range(0, 3) != 0;
      flush = $urandom_range(0, 299) == 0;
    end
    flush = 1'b0; resp_rdy = 1'b1;
    idle(80);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/blockram_port_arbiter.md
# blockram_port_arbiter

Shares one `dual_port_blockram` (ReadFirst, valid array enabled) among NUM_REQUEST requesters. Per cycle it issues at most one write and one read, each chosen by its own round-robin. It routes read data back through a 2-entry response buffer with backpressure and blocks same-cycle read-after-write hazards. It also provides a zero-fill flush sequencer, and sits directly in front of the RAM as its only driver.

## Interface
- NUM_REQUEST, 4, number of requesters (≥2)
- SINGLE_ENTRY_WIDTH_IN_BITS, 64, RAM entry width
- NUM_SET, 64, RAM depth (power of 2)
- SET_PTR_WIDTH_IN_BITS, $clog2(NUM_SET), set address width
- WRITE_MASK_LEN, SINGLE_ENTRY_WIDTH_IN_BITS / `BYTE_LEN_IN_BITS, byte-enable width
- REQUEST_ID_WIDTH, $clog2(NUM_REQUEST), requester id width
- clk_in  input  1  single clock, rising edge
- reset_n_in  input  1  asynchronous, active-low reset
- request_valid_in  input  NUM_REQUEST  per-requester request valid
- request_is_write_in  input  NUM_REQUEST  1 = write, 0 = read
- request_addr_in  input  NUM_REQUEST*SET_PTR_WIDTH_IN_BITS  packed set addresses; requester i at slice i
- request_data_in  input  NUM_REQUEST*SINGLE_ENTRY_WIDTH_IN_BITS  packed write data
- request_write_mask_in  input  NUM_REQUEST*WRITE_MASK_LEN  packed byte enables
- request_ready_out  output  NUM_REQUEST  grant; a transfer occurs when valid & ready
- response_valid_out  output  1  read response available
- response_ready_in  input  1  consumer accepts response
- response_id_out  output  REQUEST_ID_WIDTH  requester of response
- response_data_out  output  SINGLE_ENTRY_WIDTH_IN_BITS  read data
- response_hit_out  output  1  RAM valid bit for the set
- flush_in  input  1  start zero-fill of all sets
- busy_out  output  1  flush sequencer not IDLE
- flush_done_out  output  1  one-cycle pulse at flush completion
- ram_write_access_en_out, ram_write_en_out [WRITE_MASK_LEN], ram_write_set_addr_out, ram_write_data_out  output  RAM write port
- ram_read_access_en_out, ram_read_set_addr_out  output  RAM read port
- ram_read_data_in  input  SINGLE_ENTRY_WIDTH_IN_BITS  RAM read data (1-cycle latency)
- ram_read_valid_in  input  1  RAM read valid bit

## Operation
- Requester protocol: valid, is_write, addr, data and mask are held stable until ready. Ready is combinational from the current valids and state.
- Write arbitration: round-robin over requesters with valid & is_write. The pointer holds the last granted index, and priority starts at pointer+1. The winner drives the RAM write port in the same cycle. Writes are posted; there is no response.
- Read arbitration: independent round-robin over valid & !is_write. A read is granted only when credit holds: occupancy + inflight − pop < 2, where pop = response_valid_out & response_ready_in. ram_read_access_en_out is asserted only on grant.
- Hazard: if the read winner's address equals the granted write's address with write mask ≠ 0, the read is not granted that cycle and its read pointer is unchanged.
- A pointer updates only when its arbiter grants.
- Response path:
  - inflight and inflight_id are registered on read grant.
  - The next cycle, {ram_read_data_in, ram_read_valid_in, id} is pushed into a 2-entry FIFO.
  - The head of the FIFO drives the response outputs. response_valid_out = occupancy ≠ 0.
  - Responses are delivered in grant order.
- Flush FSM has states IDLE → FLUSH → DONE → IDLE.
  - IDLE: flush_in = 1 moves to FLUSH with set counter = 0. No grants are issued in that cycle.
  - FLUSH: writes set counter with data 0 and mask all ones, then increments the counter. On counter = NUM_SET−1, moves to DONE.
  - DONE: flush_done_out = 1, then returns to IDLE.
  - In FLUSH and DONE, request_ready_out = 0. flush_in is ignored outside IDLE.
  - Reads already in flight and the FIFO keep draining during a flush.
- Reset: asynchronous on reset_n_in low.
  - FSM goes to IDLE; both pointers = NUM_REQUEST−1, so requester 0 wins first.
  - FIFO is emptied, inflight = 0, and all registered outputs = 0.
  - While reset is asserted, request_ready_out and the RAM enables are 0.
  - Reset in mid-flush abandons the flush; no flush_done_out pulse is produced.

## Timing
- Write: granted at cycle T and written into the RAM at the T edge.
- Read:
  - Grant at T, with RAM address driven at T.
  - RAM data is valid at T+1 and pushed into the FIFO at the T+1 edge.
  - response_valid_out is high at T+2 at the earliest.
- Sustained throughput is 1 read + 1 write per cycle while response_ready_in stays high.
- With response_ready_in held low, exactly 2 reads are granted before read grants stop.
- Flush: flush_in is sampled at T. Writes occur in cycles T+1 … T+NUM_SET, flush_done_out is high at T+NUM_SET+1, and requests may be granted again from T+NUM_SET+2.

## Test plan
- Req0 writes addr 5, data 0x1122334455667788, mask 0xFF; then req0 reads addr 5 → response 2 cycles after the read grant with id 0, data 0x1122334455667788, hit 1.
- Req0–3 all continuously read addr i → grants in order 0,1,2,3,0,…, one per cycle; response ids follow the same order.
- response_ready_in = 0 with 4 reads pending → only 2 grants, response_valid_out stays high; raise ready → the remaining 2 are granted, and all 4 responses arrive in order.
- Same cycle: req0 writes addr 9 data 0xAA…AA, req1 reads addr 9 → write granted and read held off; the read is granted the next cycle and returns 0xAA…AA.
- flush_in after several writes → 64 consecutive writes to addr 0..63 with mask 0xFF and data 0, all request_ready_out = 0 throughout, flush_done_out at T+65; a read of addr 5 then returns data 0 with hit 1.
- reset_n_in pulled low with the flush counter at 10 and one response buffered → all outputs drop to 0 immediately with no clock edge; after release busy_out = 0, response_valid_out = 0, and requester 0 wins first.
